mem_arbiter: RTL

Two-requester round-robin arbiter and access sequencer for the single-port data Memory (4-bit address, 8-bit data, read on negedge, write on posedge). Each requester issues one read or write with a req/ack handshake. The block drives Memory's address, writeData, MemRead and MemWrite from registers, captures dataOut, and returns it to the winning requester. It sits between the processor's fetch/load-store units and Memory.

---
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter that sequences single accesses into the
// single-port data Memory and returns read data to the winning requester.
module mem_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              win_q, win_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              busy_q, busy_d;

  logic              grant_sel;

  // Lone requester wins outright; on contention the pointer decides.
  always_comb begin
    grant_sel = (req0 && req1) ? ptr_q : req1;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    ack0_d      = ack0_q;
    ack1_d      = ack1_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    busy_d      = busy_q;

    unique case (state_q)
      IDLE: begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        if (req0 || req1) begin
          win_d       = grant_sel;
          mem_addr_d  = grant_sel ? addr1 : addr0;
          mem_wdata_d = grant_sel ? wdata1 : wdata0;
          mem_write_d = grant_sel ? we1 : we0;
          mem_read_d  = grant_sel ? !we1 : !we0;
          busy_d      = 1'b1;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        // Memory produced dataOut at the mid-cycle negedge; capture it now.
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        if (win_q) begin
          ack1_d = 1'b1;
          if (mem_read_q) rdata1_d = mem_rdata;
        end else begin
          ack0_d = 1'b1;
          if (mem_read_q) rdata0_d = mem_rdata;
        end
        ptr_d   = !win_q;
        state_d = DONE;
      end
      DONE: begin
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      win_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      busy_q      <= busy_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign busy      = busy_q;

endmodule
